mlbmp_plot: RTL and testbench

Host-side pixel writer for the 1-bpp mono bitmap framebuffer, the write-side counterpart of the display scan-out path. It accepts single-pixel set/clear/toggle commands and a whole-screen fill command. It performs the required byte read-modify-write or fill writes on the shared screen-RAM port through a request/grant handshake. The address and bit mapping are identical to scan-out, so plotted pixels appear un-mirrored.

---
 rtl/fb_pkg.sv | 37 +++
 rtl/mlbmp_plot_if.sv | 30 +++
 rtl/mlbmp_pix_addr.sv | 14 +
 rtl/mlbmp_plot.sv | 148 ++++++++++++++
 tb/tb_mlbmp_plot.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the 1-bpp mono bitmap framebuffer (scan-out and host write side).
package fb_pkg;

    localparam int unsigned SCR_AW    = 16;
    localparam int unsigned BMP_W     = 320;
    localparam int unsigned BMP_H     = 240;
    localparam int unsigned COL_W     = 9;
    localparam int unsigned ROW_W     = 8;
    localparam int unsigned ROW_LSB   = 8;
    localparam int unsigned BIDX_W    = 6;

    typedef enum logic [1:0] {
        OP_SET  = 2'b00,
        OP_CLR  = 2'b01,
        OP_TGL  = 2'b10,
        OP_FILL = 2'b11
    } op_e;

    // Screen address {row, 2'b00, byte}; the two gap bits keep rows on a 256-byte pitch.
    function automatic logic [SCR_AW-1:0] scr_addr(logic [ROW_W-1:0] row,
                                                   logic [BIDX_W-1:0] bidx);
        return {row, 2'b00, bidx};
    endfunction

    function automatic logic [7:0] apply_op(op_e op, logic [7:0] rdata, logic [7:0] mask);
        logic [7:0] res;
        res = rdata;
        case (op)
            OP_SET:  res = rdata | mask;
            OP_CLR:  res = rdata & ~mask;
            OP_TGL:  res = rdata ^ mask;
            default: res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mlbmp_plot_if.sv
// Command and screen-RAM bus of the bitmap pixel writer.
interface mlbmp_plot_if;
    import fb_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [COL_W-1:0]  cmd_col;
    logic [ROW_W-1:0]  cmd_row;
    logic              cmd_fill;
    logic              done;
    logic              err;
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [SCR_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_col, cmd_row, cmd_fill, mem_gnt, mem_rdata,
        input  cmd_ready, done, err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_col, cmd_row, cmd_fill, mem_gnt, mem_rdata,
        output cmd_ready, done, err, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mlbmp_pix_addr.sv
// Pixel coordinate to screen byte address and bit mask; column 0 is the byte MSB.
module mlbmp_pix_addr
    import fb_pkg::*;
(
    input  logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  row,
    output logic [SCR_AW-1:0] addr,
    output logic [7:0]        mask
);

    assign addr = scr_addr(row, col[COL_W-1:3]);
    assign mask = 8'h80 >> col[2:0];

endmodule

// File: rtl/mlbmp_plot.sv
// Host pixel writer: set/clear/toggle via byte read-modify-write, or whole-screen fill,
// over a request/grant screen-RAM port.
module mlbmp_plot
    import fb_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned COL_BYTES = 40,
    parameter int unsigned ROWS      = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    mlbmp_plot_if.slave bus
);

    localparam logic [COL_W:0]      ColLim   = (COL_W + 1)'(COL_BYTES * 8);
    localparam logic [ROW_W:0]      RowLim   = (ROW_W + 1)'(ROWS);
    localparam logic [ROW_W-1:0]    RowLast  = ROW_W'(ROWS - 1);
    localparam logic [BIDX_W-1:0]   BidxLast = BIDX_W'(COL_BYTES - 1);
    localparam logic [1:0]          WaitInit = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {StIdle, StRd, StRwait, StWr, StFill, StDone} state_e;

    state_e            state_q;
    op_e               op_q;
    logic [7:0]        mask_q;
    logic [1:0]        wait_q;
    logic [ROW_W-1:0]  r_q;
    logic [BIDX_W-1:0] b_q;
    logic              mem_req_q, mem_we_q, done_q, err_q;
    logic [SCR_AW-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic [SCR_AW-1:0] pix_addr;
    logic [7:0]        pix_mask;
    logic              in_range;
    logic              fill_last;

    mlbmp_pix_addr u_pix_addr (
        .col  (bus.cmd_col),
        .row  (bus.cmd_row),
        .addr (pix_addr),
        .mask (pix_mask)
    );

    assign in_range  = ({1'b0, bus.cmd_col} < ColLim) && ({1'b0, bus.cmd_row} < RowLim);
    assign fill_last = (r_q == RowLast) && (b_q == BidxLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= OP_SET;
            mask_q      <= '0;
            wait_q      <= '0;
            r_q         <= '0;
            b_q         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        op_q   <= op_e'(bus.cmd_op);
                        mask_q <= pix_mask;
                        if (op_e'(bus.cmd_op) == OP_FILL) begin
                            state_q     <= StFill;
                            r_q         <= '0;
                            b_q         <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= scr_addr('0, '0);
                            mem_wdata_q <= {8{bus.cmd_fill}};
                        end else if (!in_range) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q    <= StRd;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= pix_addr;
                        end
                    end
                end
                StRd: begin
                    if (bus.mem_gnt) begin
                        state_q   <= StRwait;
                        mem_req_q <= 1'b0;
                        wait_q    <= WaitInit;
                    end
                end
                StRwait: begin
                    if (wait_q == 2'd0) begin
                        state_q     <= StWr;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= apply_op(op_q, bus.mem_rdata, mask_q);
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                StWr: begin
                    if (bus.mem_gnt) begin
                        state_q   <= StDone;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                StFill: begin
                    if (bus.mem_gnt) begin
                        if (fill_last) begin
                            state_q   <= StDone;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            done_q    <= 1'b1;
                        end else if (b_q == BidxLast) begin
                            b_q        <= '0;
                            r_q        <= r_q + 1'b1;
                            mem_addr_q <= scr_addr(r_q + 1'b1, '0);
                        end else begin
                            b_q        <= b_q + 1'b1;
                            mem_addr_q <= scr_addr(r_q, b_q + 1'b1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mlbmp_plot.sv
// Bench for mlbmp_plot: pixel-level reference model against a byte RAM model, plus a
// directed RD_LAT=3 stall/reset scenario on a second instance.
module tb_mlbmp_plot;

    logic clk = 1'b0;
    logic rst_n, rst3_n;
    always #5 clk = ~clk;

    mlbmp_plot_if bus ();
    mlbmp_plot_if bus3 ();

    mlbmp_plot #(.RD_LAT(1), .COL_BYTES(40), .ROWS(240)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mlbmp_plot #(.RD_LAT(3), .COL_BYTES(40), .ROWS(240)) u_dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (bus3.slave)
    );

    int n_cmp = 0;
    int n_fail = 0;

    bit pix [0:239][0:319];
    logic [7:0] ram [0:65535];

    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    logic [15:0] last_rd_addr, last_wr_addr;
    logic [7:0]  last_wdata;
    bit gnt_rand = 1'b0;
    bit fill_mon = 1'b0;
    int fill_idx = 0, fill_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected byte built from the pixel array: leftmost pixel of the 8-pixel group is the MSB.
    function automatic logic [7:0] exp_byte(int row, int bidx);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[7-k] = pix[row][bidx*8+k];
        return v;
    endfunction

    // RAM model for the RD_LAT=1 instance: transfer on an edge with req && gnt.
    always begin
        logic       s_xfer, s_we, rd_now;
        logic [15:0] s_addr;
        logic [7:0]  s_wdata, rd_val;
        int          exp_a;
        @(negedge clk);
        s_xfer  = bus.mem_req && bus.mem_gnt;
        s_we    = bus.mem_we;
        s_addr  = bus.mem_addr;
        s_wdata = bus.mem_wdata;
        if (bus.done === 1'b1) done_cnt++;
        @(posedge clk);
        rd_now = 1'b0;
        rd_val = 8'h00;
        if (s_xfer) begin
            if (s_we) begin
                ram[s_addr] = s_wdata;
                wr_cnt++;
                last_wr_addr = s_addr;
                last_wdata   = s_wdata;
                if (fill_mon) begin
                    exp_a = (fill_idx / 40) * 256 + (fill_idx % 40);
                    if (s_addr !== 16'(exp_a) || s_wdata !== 8'hFF) fill_bad++;
                    fill_idx++;
                end
            end else begin
                rd_cnt++;
                last_rd_addr = s_addr;
                rd_now = 1'b1;
                rd_val = ram[s_addr];
                if (fill_mon) fill_bad++;
            end
        end
        #1;
        bus.mem_rdata = rd_now ? rd_val : 8'($urandom);
        bus.mem_gnt   = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Offers one command, then waits (bounded) for done. lat counts the accept cycle as 1.
    task automatic do_cmd(input logic [1:0] op, input logic [8:0] col, input logic [7:0] row,
                          input logic fill, output int lat, output logic err_seen,
                          output logic busy_ready, output logic done_after);
        @(negedge clk);
        chk("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_col   = col;
        bus.cmd_row   = row;
        bus.cmd_fill  = fill;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        lat = -1;
        err_seen = 1'b0;
        busy_ready = 1'b1;
        for (int i = 1; i < 40000; i++) begin
            @(negedge clk);
            if (i == 1) busy_ready = bus.cmd_ready;
            if (bus.done === 1'b1) begin
                lat = i;
                err_seen = bus.err;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        done_after = bus.done;
    endtask

    task automatic apply_pix(input int op, input int col, input int row);
        case (op)
            0: pix[row][col] = 1'b1;
            1: pix[row][col] = 1'b0;
            default: pix[row][col] = ~pix[row][col];
        endcase
    endtask

    initial begin
        int lat, rd0, wr0, dn0, op, col, row;
        logic errs, bready, dafter;
        bit stall_ok;

        rst_n = 1'b0;
        rst3_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_col = '0; bus.cmd_row = '0;
        bus.cmd_fill = 1'b0; bus.mem_gnt = 1'b1; bus.mem_rdata = 8'h00;
        bus3.cmd_valid = 1'b0; bus3.cmd_op = 2'b00; bus3.cmd_col = '0; bus3.cmd_row = '0;
        bus3.cmd_fill = 1'b0; bus3.mem_gnt = 1'b0; bus3.mem_rdata = 8'h00;

        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        for (int r = 0; r < 240; r++)
            for (int c = 0; c < 320; c++) pix[r][c] = 1'($urandom);
        for (int c = 0; c < 8; c++) pix[0][c] = 1'b0;
        for (int c = 8; c < 16; c++) pix[5][c] = 1'b1;
        for (int c = 312; c < 320; c++) pix[239][c] = 1'b0;
        for (int r = 0; r < 240; r++)
            for (int b = 0; b < 40; b++) ram[r*256 + b] = exp_byte(r, b);

        #2;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        rst3_n = 1'b1;

        // Set (0,0) on byte 8'h00 with grant tied high.
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_cmd(2'b00, 9'd0, 8'd0, 1'b0, lat, errs, bready, dafter);
        apply_pix(0, 0, 0);
        chk("set_latency", 32'(lat), 32'd4);
        chk("set_err", 32'(errs), 32'd0);
        chk("set_busy_not_ready", 32'(bready), 32'd0);
        chk("set_done_one_cycle", 32'(dafter), 32'd0);
        chk("set_rd_addr", 32'(last_rd_addr), 32'h0000);
        chk("set_wr_addr", 32'(last_wr_addr), 32'h0000);
        chk("set_wdata", 32'(last_wdata), 32'h80);
        chk("set_access_count", 32'((rd_cnt - rd0) * 16 + (wr_cnt - wr0)), 32'h11);

        // Clear (13,5) on byte 8'hFF.
        do_cmd(2'b01, 9'd13, 8'd5, 1'b0, lat, errs, bready, dafter);
        apply_pix(1, 13, 5);
        chk("clr_wr_addr", 32'(last_wr_addr), 32'h0501);
        chk("clr_wdata", 32'(last_wdata), 32'hFB);
        chk("clr_err", 32'(errs), 32'd0);

        // Toggle the last pixel twice.
        do_cmd(2'b10, 9'd319, 8'd239, 1'b0, lat, errs, bready, dafter);
        apply_pix(2, 319, 239);
        chk("tgl1_wr_addr", 32'(last_wr_addr), 32'hEF27);
        chk("tgl1_wdata", 32'(last_wdata), 32'h01);
        do_cmd(2'b10, 9'd319, 8'd239, 1'b0, lat, errs, bready, dafter);
        apply_pix(2, 319, 239);
        chk("tgl2_wdata", 32'(last_wdata), 32'h00);

        // Out-of-range coordinates: no RAM access, done+err one cycle after accept.
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_cmd(2'b00, 9'd320, 8'd0, 1'b0, lat, errs, bready, dafter);
        chk("oor_col_latency", 32'(lat), 32'd1);
        chk("oor_col_err", 32'(errs), 32'd1);
        chk("oor_col_no_access", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
        do_cmd(2'b01, 9'd5, 8'd240, 1'b0, lat, errs, bready, dafter);
        chk("oor_row_err", 32'(errs), 32'd1);
        chk("oor_row_no_access", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);

        // Random pixel commands with a 50% grant.
        gnt_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            op  = $urandom_range(0, 2);
            col = $urandom_range(0, 335);
            row = $urandom_range(0, 250);
            rd0 = rd_cnt; wr0 = wr_cnt;
            do_cmd(2'(op), 9'(col), 8'(row), 1'b0, lat, errs, bready, dafter);
            if (col < 320 && row < 240) begin
                apply_pix(op, col, row);
                chk("rnd_byte", 32'(ram[row*256 + col/8]), 32'(exp_byte(row, col/8)));
                chk("rnd_err", 32'(errs), 32'd0);
                chk("rnd_access_count", 32'((rd_cnt - rd0) * 16 + (wr_cnt - wr0)), 32'h11);
            end else begin
                chk("rnd_oor_err", 32'(errs), 32'd1);
                chk("rnd_oor_no_access", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
            end
        end

        // Whole-screen fill with ones under random grant.
        rd0 = rd_cnt; dn0 = done_cnt;
        fill_idx = 0; fill_bad = 0; fill_mon = 1'b1;
        do_cmd(2'b11, 9'd0, 8'd0, 1'b1, lat, errs, bready, dafter);
        fill_mon = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("fill_write_count", 32'(fill_idx), 32'd9600);
        chk("fill_order_data", 32'(fill_bad), 32'd0);
        chk("fill_no_reads", 32'(rd_cnt - rd0), 32'd0);
        chk("fill_err", 32'(errs), 32'd0);
        chk("fill_single_done", 32'(done_cnt - dn0), 32'd1);
        chk("fill_byte_first", 32'(ram[16'h0000]), 32'hFF);
        chk("fill_byte_mid", 32'(ram[16'h7814]), 32'hFF);
        chk("fill_byte_last", 32'(ram[16'hEF27]), 32'hFF);
        gnt_rand = 1'b0;

        // RD_LAT=3 instance: stalled read grant, delayed sample, reset during write.
        @(negedge clk);
        bus3.cmd_valid = 1'b1; bus3.cmd_op = 2'b00; bus3.cmd_col = 9'd10; bus3.cmd_row = 8'd2;
        @(posedge clk);
        #1 bus3.cmd_valid = 1'b0;
        stall_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus3.mem_req !== 1'b1 || bus3.mem_we !== 1'b0 || bus3.mem_addr !== 16'h0201)
                stall_ok = 1'b0;
        end
        chk("stall_req_held", 32'(stall_ok), 32'd1);
        bus3.mem_gnt = 1'b1;
        @(posedge clk);
        #1 bus3.mem_gnt = 1'b0;
        bus3.mem_rdata = 8'h50;
        @(negedge clk);
        chk("lat3_req_released", 32'(bus3.mem_req), 32'd0);
        @(posedge clk);
        #1 bus3.mem_rdata = 8'h81;
        @(posedge clk);
        #1 bus3.mem_rdata = 8'h0F;
        @(posedge clk);
        #1 bus3.mem_rdata = 8'h44;
        @(negedge clk);
        chk("lat3_wr_req", {30'd0, bus3.mem_req, bus3.mem_we}, 32'd3);
        chk("lat3_wdata", 32'(bus3.mem_wdata), 32'h2F);
        chk("lat3_wr_addr", 32'(bus3.mem_addr), 32'h0201);
        #2 rst3_n = 1'b0;
        #1;
        chk("midwr_rst_req", 32'(bus3.mem_req), 32'd0);
        chk("midwr_rst_ready", 32'(bus3.cmd_ready), 32'd1);
        chk("midwr_rst_done", 32'(bus3.done), 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("post_rst_idle", {30'd0, bus3.cmd_ready, bus3.mem_req}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
